// File: rtl/xbus_master_arb.sv
// Two-master round-robin Xbus arbiter: one registered transaction at a time, 4-cycle req-to-ack with a 2-stage-ack slave.
// Backpressure: the loser's request stays pending; DONE/ERR hold until the winner drops req and the slave ack tail clears.
module xbus_master_arb #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [21:0] m0_addr,
  input  logic [31:0] m0_datain,
  input  logic        m0_req,
  input  logic        m0_write,
  output logic [31:0] m0_dataout,
  output logic        m0_ack,
  output logic        m0_buserr,
  input  logic [21:0] m1_addr,
  input  logic [31:0] m1_datain,
  input  logic        m1_req,
  input  logic        m1_write,
  output logic [31:0] m1_dataout,
  output logic        m1_ack,
  output logic        m1_buserr,
  output logic [21:0] x_addr,
  output logic [31:0] x_dataout,
  output logic        x_req,
  output logic        x_write,
  input  logic [31:0] x_datain,
  input  logic        x_ack,
  input  logic        x_decode,
  output logic        grant,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic       last;
  logic [7:0] cnt;
  logic       any_req;
  logic       win;
  logic       win_req;
  logic       unused_decode;

  // Decode is informational; completion depends only on x_ack.
  assign unused_decode = x_decode;

  assign any_req = m0_req | m1_req;
  assign win     = (m0_req & m1_req) ? ~last : m1_req;
  assign win_req = grant ? m1_req : m0_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last       <= 1'b1;
      grant      <= 1'b0;
      busy       <= 1'b0;
      cnt        <= '0;
      x_req      <= 1'b0;
      x_write    <= 1'b0;
      x_addr     <= '0;
      x_dataout  <= '0;
      m0_ack     <= 1'b0;
      m0_buserr  <= 1'b0;
      m0_dataout <= '0;
      m1_ack     <= 1'b0;
      m1_buserr  <= 1'b0;
      m1_dataout <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            x_addr    <= win ? m1_addr : m0_addr;
            x_dataout <= win ? m1_datain : m0_datain;
            x_write   <= win ? m1_write : m0_write;
            grant     <= win;
            last      <= win;
            cnt       <= '0;
            x_req     <= 1'b1;
            busy      <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          // A coincident ack beats the timeout.
          if (x_ack) begin
            x_req <= 1'b0;
            if (grant) begin
              m1_dataout <= x_datain;
              m1_ack     <= 1'b1;
            end else begin
              m0_dataout <= x_datain;
              m0_ack     <= 1'b1;
            end
            state <= DONE;
          end else if (cnt == TO_LAST) begin
            x_req <= 1'b0;
            if (grant) begin
              m1_dataout <= '0;
              m1_buserr  <= 1'b1;
            end else begin
              m0_dataout <= '0;
              m0_buserr  <= 1'b1;
            end
            state <= ERR;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE, ERR: begin
          // Waiting for x_ack low keeps a stale ack from completing the next grant.
          if (!win_req && !x_ack) begin
            m0_ack    <= 1'b0;
            m0_buserr <= 1'b0;
            m1_ack    <= 1'b0;
            m1_buserr <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xbus_master_arb.sv
// Directed bench for xbus_master_arb with a two-stage-ack slave model and TIMEOUT = 8.
module tb_xbus_master_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [21:0] m0_addr, m1_addr, x_addr;
  logic [31:0] m0_datain, m1_datain, m0_dataout, m1_dataout, x_dataout, x_datain;
  logic        m0_req, m1_req, m0_write, m1_write;
  logic        m0_ack, m1_ack, m0_buserr, m1_buserr;
  logic        x_req, x_write, x_ack, x_decode, grant, busy;

  logic        slave_en;
  logic [31:0] rdata;
  logic        s1, s2;

  int n_cmp = 0;
  int n_bad = 0;
  int lat, nreq, got, gap;

  xbus_master_arb #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .m0_addr(m0_addr), .m0_datain(m0_datain), .m0_req(m0_req), .m0_write(m0_write),
    .m0_dataout(m0_dataout), .m0_ack(m0_ack), .m0_buserr(m0_buserr),
    .m1_addr(m1_addr), .m1_datain(m1_datain), .m1_req(m1_req), .m1_write(m1_write),
    .m1_dataout(m1_dataout), .m1_ack(m1_ack), .m1_buserr(m1_buserr),
    .x_addr(x_addr), .x_dataout(x_dataout), .x_req(x_req), .x_write(x_write),
    .x_datain(x_datain), .x_ack(x_ack), .x_decode(x_decode),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_cmp++;
    if (got_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 40 && busy; i++) step();
    check("idle_return", 32'(busy), 32'd0);
  endtask

  // Slave: x_ack seen by the DUT two cycles after x_req, tail of two cycles after x_req falls.
  initial begin
    x_ack = 1'b0; x_datain = '0; x_decode = 1'b0; s1 = 1'b0; s2 = 1'b0;
    forever begin
      @(negedge clk);
      x_ack    = s2 & slave_en;
      x_datain = (s2 & slave_en) ? rdata : 32'd0;
      x_decode = s2 & slave_en;
      s2       = s1;
      s1       = x_req;
    end
  end

  initial begin
    reset = 1'b1; slave_en = 1'b1; rdata = '0;
    m0_addr = '0; m0_datain = '0; m0_req = 1'b0; m0_write = 1'b0;
    m1_addr = '0; m1_datain = '0; m1_req = 1'b0; m1_write = 1'b0;
    repeat (3) step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_x_req", 32'(x_req), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_x_addr", 32'(x_addr), 32'd0);
    check("rst_acks", 32'({m0_ack, m1_ack, m0_buserr, m1_buserr}), 32'd0);
    check("rst_m1_dataout", m1_dataout, 32'd0);
    reset = 1'b0;
    step();

    // Single m1 read
    rdata = 32'h0000_1234;
    m1_addr = 22'o17772037; m1_req = 1'b1;
    lat = 0; nreq = 0;
    for (int i = 0; i < 20; i++) begin
      step(); lat++;
      if (x_req) nreq++;
      if (i == 0) begin
        check("rd_grant", 32'(grant), 32'd1);
        check("rd_x_addr", 32'(x_addr), 32'(22'o17772037));
        check("rd_x_write", 32'(x_write), 32'd0);
      end
      if (m1_ack) break;
    end
    check("rd_latency", 32'(lat), 32'd4);
    check("rd_data", m1_dataout, 32'h0000_1234);
    check("rd_xreq_cycles", 32'(nreq), 32'd3);
    check("rd_m0_quiet", 32'({m0_ack, m0_buserr}), 32'd0);
    check("rd_m0_dataout", m0_dataout, 32'd0);
    m1_req = 1'b0;
    wait_idle();

    // Contention: four rounds, tie broken by last winner
    m0_addr = 22'o100; m1_addr = 22'o200;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int r = 0; r < 4; r++) begin
      got = 2;
      for (int i = 0; i < 30; i++) begin
        step();
        if (m0_ack | m1_ack) begin
          got = m1_ack ? 1 : 0;
          break;
        end
      end
      check("arb_winner", 32'(got), 32'(r % 2));
      check("arb_one_ack", 32'(m0_ack & m1_ack), 32'd0);
      if (got == 1) m1_req = 1'b0; else m0_req = 1'b0;
      for (int i = 0; i < 20 && (m0_ack | m1_ack); i++) step();
      if (r < 3) begin
        if (got == 1) m1_req = 1'b1; else m0_req = 1'b1;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    wait_idle();

    // m0 write; master-side changes during BUSY must not reach the bus
    rdata = 32'hDEAD_BEEF;
    m0_addr = 22'o17772045; m0_datain = 32'h0000_000A; m0_write = 1'b1; m0_req = 1'b1;
    step();
    check("wr_grant", 32'(grant), 32'd0);
    m0_datain = 32'hFFFF_FFFF; m0_addr = '0; m0_write = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (x_req) begin
        check("wr_x_write", 32'(x_write), 32'd1);
        check("wr_x_dataout", x_dataout, 32'h0000_000A);
        check("wr_x_addr", 32'(x_addr), 32'(22'o17772045));
      end
      if (m0_ack) break;
      step();
    end
    check("wr_ack", 32'(m0_ack), 32'd1);
    check("wr_done_x_req", 32'(x_req), 32'd0);
    m0_req = 1'b0;
    wait_idle();

    // Timeout on an unmapped address
    slave_en = 1'b0;
    m0_addr = 22'o17700000; m0_req = 1'b1;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      step(); lat++;
      if (m0_buserr) break;
    end
    check("to_latency", 32'(lat), 32'd9);
    check("to_dataout", m0_dataout, 32'd0);
    check("to_no_ack", 32'(m0_ack), 32'd0);
    check("to_x_req", 32'(x_req), 32'd0);
    check("to_m1_quiet", 32'(m1_buserr), 32'd0);
    m0_req = 1'b0;
    step();
    check("to_exit_busy", 32'(busy), 32'd0);
    check("to_exit_buserr", 32'(m0_buserr), 32'd0);
    slave_en = 1'b1; rdata = 32'h0000_5A5A;
    m0_req = 1'b1; lat = 0;
    for (int i = 0; i < 20; i++) begin
      step(); lat++;
      if (m0_ack) break;
    end
    check("to_next_latency", 32'(lat), 32'd4);
    check("to_next_data", m0_dataout, 32'h0000_5A5A);
    m0_req = 1'b0;
    wait_idle();

    // Stale ack tail must not complete m1's queued request
    rdata = 32'h0000_0BAD;
    m0_req = 1'b1;
    for (int i = 0; i < 20 && !m0_ack; i++) step();
    check("st_m0_ack", 32'(m0_ack), 32'd1);
    m0_req = 1'b0; m1_req = 1'b1; rdata = 32'h1111_2222;
    gap = 0;
    for (int i = 0; i < 20; i++) begin
      step(); gap++;
      if (x_req) break;
      check("st_no_m1_ack", 32'(m1_ack), 32'd0);
    end
    check("st_regrant_gap", 32'(gap), 32'd4);
    check("st_grant", 32'(grant), 32'd1);
    lat = 0;
    for (int i = 0; i < 20 && !m1_ack; i++) begin
      step(); lat++;
    end
    check("st_m1_latency", 32'(lat), 32'd3);
    check("st_m1_data", m1_dataout, 32'h1111_2222);
    m1_req = 1'b0;
    wait_idle();

    // Reset in the middle of BUSY
    m0_addr = 22'o1111; m1_addr = 22'o2222;
    m0_req = 1'b1; m1_req = 1'b1;
    step();
    check("rb_busy_pre", 32'(x_req), 32'd1);
    reset = 1'b1;
    step();
    check("rb_x_req", 32'(x_req), 32'd0);
    check("rb_busy", 32'(busy), 32'd0);
    check("rb_acks", 32'({m0_ack, m1_ack, m0_buserr, m1_buserr}), 32'd0);
    repeat (3) step();
    reset = 1'b0;
    step();
    check("rb_first_grant", 32'(grant), 32'd0);
    check("rb_first_addr", 32'(x_addr), 32'(22'o1111));
    m0_req = 1'b0; m1_req = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/xbus_master_arb.md
# xbus_master_arb

Two-master arbiter and transaction sequencer for the Xbus. It sits between two bus masters and the shared Xbus slave fabric: master 0 is the disk/DMA engine and master 1 is the CPU memory/IO port. The slaves are xbus_io, memory and similar devices, whose decode, ack and read data are ORed onto the fabric. The block grants the bus round-robin, registers one transaction at a time onto the Xbus, waits for the slave ack, and returns data, ack or a bus error to the winning master.

## Interface
- TIMEOUT, 64: cycles of x_req without x_ack before a bus error is signalled (1..255).
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- m0_addr  in  22  master 0 word address.
- m0_datain  in  32  master 0 write data.
- m0_req  in  1  master 0 request; level, held until m0_ack or m0_buserr.
- m0_write  in  1  master 0 direction (1 = write).
- m0_dataout  out  32  master 0 read data; valid while m0_ack.
- m0_ack  out  1  master 0 transaction complete.
- m0_buserr  out  1  master 0 transaction timed out.
- m1_addr, m1_datain, m1_req, m1_write, m1_dataout, m1_ack, m1_buserr: identical, for master 1.
- x_addr  out  22  registered Xbus address.
- x_dataout  out  32  registered Xbus write data.
- x_req  out  1  Xbus request.
- x_write  out  1  Xbus direction.
- x_datain  in  32  ORed slave read data.
- x_ack  in  1  ORed slave ack.
- x_decode  in  1  ORed slave decode; informational only, not required for completion.
- grant  out  1  index of the current or last owner.
- busy  out  1  1 in every state except IDLE.

## Operation
- States: IDLE, BUSY, DONE, ERR.
- IDLE: when any m*_req is high, select a winner.
  - Only one master requesting: that master wins.
  - Both requesting: the master that is not `last` wins. `last` resets to 1, so m0 wins the first tie.
  - Latch the winner's addr, datain and write into x_addr, x_dataout and x_write.
  - Set grant, update last, clear the timeout counter, go to BUSY.
- BUSY:
  - x_req = 1. The counter increments each cycle.
  - On x_ack = 1: latch x_datain into the winner's m*_dataout (writes latch as well; the value is don't-care) and go to DONE.
  - Otherwise, when the counter reaches TIMEOUT-1: go to ERR.
  - If x_ack and the timeout coincide, ack wins.
- DONE:
  - x_req = 0. The winner's m*_ack = 1; m*_dataout is held.
  - Leave for IDLE when the winner's req = 0 AND x_ack = 0. Waiting for x_ack = 0 flushes the slave ack pipeline so a stale ack cannot complete the next transaction.
- ERR:
  - x_req = 0. The winner's m*_buserr = 1 and m*_dataout = 0.
  - Exit under the same condition as DONE.
- Loser: its ack and buserr stay 0 and its request stays pending. It is granted on the next IDLE evaluation, which guarantees alternation under contention.
- Winner drops req during BUSY: the slave cycle still completes or times out. DONE/ERR then exits on the first cycle x_ack = 0.
- Write-data, address and direction changes by a master during BUSY are ignored because the values were latched at grant.
- All outputs are registered.
- Reset values (any state, including mid-transaction): state IDLE, last = 1, grant = 0, busy = 0, x_req = 0, x_write = 0, x_addr = 0, x_dataout = 0, all m*_ack/m*_buserr = 0, all m*_dataout = 0, counter = 0.
- A reset while x_req is high simply drops x_req. Slave side effects already performed are not undone.

## Timing
- Cycle N: IDLE samples req. N+1: x_req, x_addr and x_write valid (BUSY).
- With an xbus_io-class slave, x_ack rises at N+3 (two-stage ack delay), so m*_ack rises at N+4: 4-cycle request-to-ack latency.
- Read data: m*_dataout is valid in the same cycle m*_ack rises and stays stable through DONE.
- The master may drop req in the cycle after it sees ack. m*_ack falls one cycle after the exit condition is met, and IDLE can grant again in the following cycle. Minimum back-to-back spacing is therefore set by the slave ack tail (about 2 cycles after x_req falls).
- Bus error: m*_buserr rises TIMEOUT+1 cycles after the grant cycle when x_ack never rises.

## Test plan
- Single m1 read of 22'o17772037 with the slave returning 32'h0000_1234 and ack 2 cycles after x_req: m1_ack at N+4, m1_dataout = 32'h0000_1234; x_req high exactly 3 cycles; m0 outputs stay 0.
- m0 and m1 assert req in the same cycle after reset: m0 is granted first, m1 second; then both reassert together and m1 is granted first (alternation holds across 4 contended rounds).
- m0 write to 22'o17772045 with data 32'h0000_000A: x_write = 1, x_dataout = 32'h0000_000A and x_addr are stable for the entire BUSY period; m0_ack follows; x_req = 0 in DONE.
- Unmapped address with x_ack held 0 and TIMEOUT = 8: the winner's buserr rises 9 cycles after grant and dataout = 0. Then drop req: state returns to IDLE and the next request is serviced normally.
- Slave keeps x_ack high 2 cycles after x_req falls while the master drops req immediately: no new grant until x_ack = 0; the queued request from the other master is not acked by the stale ack.
- reset asserted during BUSY: next cycle x_req = 0, busy = 0 and every ack/buserr = 0; the first request after reset with both masters pending goes to m0.
